// File: rtl/status_register_unit_if.sv
// status_register_unit_if: EXE-stage ALU/control bundle and registered NZCV outputs
interface status_register_unit_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;
    logic             alu_ovf;
    logic [3:0]       exe_cmd;
    logic             s_bit;
    logic             exe_valid;
    logic             stall;
    logic             flush;
    logic             sr_wr_en;
    logic [3:0]       sr_wr_data;
    logic             exc_enter;
    logic             exc_return;
    logic [3:0]       flags;
    logic [3:0]       shadow_flags;
    logic             in_exc;
    modport master (
        output alu_result, alu_cout, alu_ovf, exe_cmd, s_bit, exe_valid, stall, flush,
               sr_wr_en, sr_wr_data, exc_enter, exc_return,
        input  flags, shadow_flags, in_exc
    );
    modport slave (
        input  alu_result, alu_cout, alu_ovf, exe_cmd, s_bit, exe_valid, stall, flush,
               sr_wr_en, sr_wr_data, exc_enter, exc_return,
        output flags, shadow_flags, in_exc
    );
endinterface

// File: rtl/status_register_unit.sv
// status_register_unit: NZCV status register with single-level exception shadow copy
module status_register_unit #(parameter int WIDTH = 32) (
    input logic clk,
    input logic rst_n,
    status_register_unit_if.slave sr
);
    logic       is_log;
    logic       is_ari;
    logic       upd;
    logic [3:0] nxt;
    // decode the ALU command and derive the candidate flags; logical ops keep C and V
    always_comb begin
        is_log = sr.exe_cmd inside {4'b0001, 4'b1001, 4'b0110, 4'b0111, 4'b1000};
        is_ari = sr.exe_cmd inside {4'b0010, 4'b0011, 4'b0100, 4'b0101};
        upd    = sr.exe_valid & sr.s_bit & ~sr.flush & (is_log | is_ari);
        nxt    = {sr.alu_result[WIDTH-1], ~|sr.alu_result,
                  is_ari ? sr.alu_cout : sr.flags[1],
                  is_ari ? sr.alu_ovf  : sr.flags[0]};
    end
    // exception entry > exception return > direct write > ALU update; stall freezes all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr.flags        <= 4'b0000;
            sr.shadow_flags <= 4'b0000;
            sr.in_exc       <= 1'b0;
        end else if (!sr.stall) begin
            if (sr.exc_enter) begin
                if (!sr.in_exc) begin
                    sr.shadow_flags <= sr.flags;
                    sr.in_exc       <= 1'b1;
                end
            end else if (sr.exc_return && sr.in_exc) begin
                sr.flags  <= sr.shadow_flags;
                sr.in_exc <= 1'b0;
            end else if (sr.sr_wr_en) begin
                sr.flags <= sr.sr_wr_data;
            end else if (upd) begin
                sr.flags <= nxt;
            end
        end
    end
endmodule
